sprite_write_scheduler: RTL

SPRITE_WRITE_SCHEDULER -- requirements
Module: sprite_write_scheduler

---
 rtl/sprite_write_scheduler_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 77 +++++++
 rtl/sprite_write_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sprite_write_scheduler_pkg.sv
// Shared definitions for the sprite write scheduler.
//   - state_e : scheduler FSM encoding (active display, draining, frame done)
//   - IndexW / ValueW / EntryW : sprite register index, data and packed entry widths
package sprite_write_scheduler_pkg;

    localparam int unsigned IndexW = 12;
    localparam int unsigned ValueW = 16;
    localparam int unsigned EntryW = IndexW + ValueW;

    typedef enum logic [1:0] {
        StActive = 2'd0,  // outside vblank, writes only accumulate
        StDrain  = 2'd1,  // in vblank, queue holds entries being forwarded
        StDone   = 2'd2   // in vblank, queue empty
    } state_e;

    // Packs an index/value pair into one queue entry, index in the upper bits.
    function automatic logic [EntryW-1:0] pack_entry(input logic [IndexW-1:0] idx,
                                                     input logic [ValueW-1:0] val);
        return {idx, val};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used as the sprite write queue.
// Ports:
//   clk_i, rst_i      : clock and asynchronous active-high reset (pointers/count only)
//   push_i, wdata_i   : enqueue request and data (ignored when full)
//   pop_i, rdata_o    : dequeue request (ignored when empty); rdata_o shows the head entry
//   full_o, empty_o   : occupancy flags
//   count_o           : current occupancy, 0..Depth
module sync_fifo #(
    parameter int unsigned Width = 28,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CountW = PtrW + 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CountW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so plain pointer increment wraps modulo Depth.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CountW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sprite_write_scheduler.sv
// Sprite write scheduler: queues CPU sprite-register writes and forwards them to the
// display controller only during vertical blank, one entry per clock in FIFO order.
// Ports:
//   clk, reset                 : clock and asynchronous active-high reset
//   cpu_write_i/index/value    : CPU write strobe and payload
//   cpu_ready_o                : queue not full (write this cycle is accepted)
//   in_vblank_i                : vertical-blank flag
//   register_write_o/index/val : registered write strobe and payload to the display
//   pending_o                  : queue occupancy
//   frame_done_o               : one-cycle pulse on entering the done state
//   overflow_o                 : sticky dropped-write flag
//   clear_overflow_i           : clears overflow_o (a same-cycle drop wins)
module sprite_write_scheduler
    import sprite_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_write_i,
    input  logic [IndexW-1:0]        cpu_index_i,
    input  logic [ValueW-1:0]        cpu_value_i,
    output logic                     cpu_ready_o,
    input  logic                     in_vblank_i,
    output logic                     register_write_o,
    output logic [IndexW-1:0]        register_index_o,
    output logic [ValueW-1:0]        register_write_value_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic                     frame_done_o,
    output logic                     overflow_o,
    input  logic                     clear_overflow_i
);

    localparam int unsigned CountW = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic               reg_write_q, reg_write_d;
    logic [IndexW-1:0]  reg_index_q, reg_index_d;
    logic [ValueW-1:0]  reg_value_q, reg_value_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;

    logic               fifo_full, fifo_empty;
    logic [CountW-1:0]  fifo_count;
    logic [EntryW-1:0]  fifo_rdata;
    logic               push, pop, drop;
    logic               next_empty;

    // Ready depends only on registered occupancy, so a pop cannot rescue a full-queue write.
    assign cpu_ready_o = (fifo_count != CountW'(DEPTH));
    assign push        = cpu_write_i && cpu_ready_o;
    assign drop        = cpu_write_i && !cpu_ready_o;
    assign pop         = in_vblank_i && !fifo_empty;

    // Queue will be empty after this edge: nothing arrives and nothing (or the last) remains.
    assign next_empty  = !push && (fifo_empty || (pop && fifo_count == CountW'(1)));

    sync_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (pack_entry(cpu_index_i, cpu_value_i)),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        reg_write_d  = pop;
        reg_index_d  = reg_index_q;
        reg_value_d  = reg_value_q;
        overflow_d   = overflow_q;

        if (!in_vblank_i) begin
            state_d = StActive;
        end else begin
            unique case (state_q)
                StActive: state_d = next_empty ? StDone : StDrain;
                StDrain:  state_d = next_empty ? StDone : StDrain;
                StDone:   state_d = next_empty ? StDone : StDrain;
                default:  state_d = StActive;
            endcase
        end

        if (pop) begin
            reg_index_d = fifo_rdata[EntryW-1:ValueW];
            reg_value_d = fifo_rdata[ValueW-1:0];
        end

        // Set has priority over clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow_i) begin
            overflow_d = 1'b0;
        end

        frame_done_d = (state_d == StDone) && (state_q != StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StActive;
            reg_write_q  <= 1'b0;
            reg_index_q  <= '0;
            reg_value_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            reg_write_q  <= reg_write_d;
            reg_index_q  <= reg_index_d;
            reg_value_q  <= reg_value_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign register_write_o       = reg_write_q;
    assign register_index_o       = reg_index_q;
    assign register_write_value_o = reg_value_q;
    assign pending_o              = fifo_count;
    assign frame_done_o           = frame_done_q;
    assign overflow_o             = overflow_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
